// File: rtl/aes_pkg.sv
// Shared AES tables, types and round-step functions.
// AES_CIPHER_DEC_EN adds the inverse tables and inverse steps.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2
  } key_len_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } cipher_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_CIPHER_DEC_EN
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

  function automatic logic [3:0] nr_of(input key_len_e kl);
    unique case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [3:0] c
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // m[k] multiplies the byte k rows below the output row
  function automatic logic [127:0] mix(
    input logic [127:0]     s,
    input logic [3:0][3:0]  m
  );
    logic [127:0] r;
    logic [7:0]   acc;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-32*c-8*j -: 8], m[(j-i)&3]);
        r[127-32*c-8*i -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] SubBytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = SBOX[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] ShiftRows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] MixColumns(input logic [127:0] s);
    return mix(s, 16'h1132);
  endfunction

  function automatic logic [127:0] AddRoundKey(
    input logic [127:0] s,
    input logic [127:0] k
  );
    return s ^ k;
  endfunction

`ifdef AES_CIPHER_DEC_EN
  function automatic logic [127:0] InvSubBytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] InvShiftRows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c-w+4)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] InvMixColumns(input logic [127:0] s);
    return mix(s, 16'h9dbe);
  endfunction
`endif

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Block in/out valid/ready bundle for the iterative AES core.
// master = block-mode controller side, slave = cipher core.
interface aes_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_dec;
  logic [1:0]   key_len;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_dec, key_len, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dec, key_len, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_cipher_iter_round.sv
// One combinational AES round, encrypt or (AES_CIPHER_DEC_EN) decrypt.
// final_i drops (Inv)MixColumns for the last round.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic         dec_i,
  input  logic         final_i,
  output logic [127:0] next_state_o
);

  logic [127:0] enc_sr;
  logic [127:0] enc_mc;
  logic [127:0] enc_o;

  assign enc_sr = ShiftRows(SubBytes(state_i));
  assign enc_mc = final_i ? enc_sr : MixColumns(enc_sr);
  assign enc_o  = AddRoundKey(enc_mc, key_i);

`ifdef AES_CIPHER_DEC_EN
  logic [127:0] dec_ark;
  logic [127:0] dec_o;

  assign dec_ark = AddRoundKey(InvSubBytes(InvShiftRows(state_i)), key_i);
  assign dec_o   = final_i ? dec_ark : InvMixColumns(dec_ark);

  assign next_state_o = dec_i ? dec_o : enc_o;
`else
  logic dec_unused;
  assign dec_unused   = dec_i;
  assign next_state_o = enc_o;
`endif

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 core, one round per clock.
// Define AES_CIPHER_DEC_EN to enable the decrypt datapath.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR_MAX         = 14,
  parameter logic [1:0]  KEYLEN_DEFAULT = 2'd0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aes_cipher_iter_if.slave        bus,
  input  logic [NR_MAX:0][127:0]  k_sch_i,
  output logic                    busy_o
);

  cipher_state_e state_q, state_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [3:0]    nr_q, nr_d;
  logic          dec_q, dec_d;
  logic [127:0]  blk_q, blk_d;

  logic [1:0]    kl_sel;
  logic [3:0]    nr_in;
  logic          dec_in;
  logic [127:0]  init_key;
  logic [3:0]    rk_idx;
  logic          last;
  logic [127:0]  rnd_out;
  logic          load;
  logic          in_ready;
  logic          out_valid;

  assign kl_sel = (bus.key_len == 2'd3) ? KEYLEN_DEFAULT
                                        : bus.key_len;
  assign nr_in  = nr_of(key_len_e'(kl_sel));

`ifdef AES_CIPHER_DEC_EN
  assign dec_in = bus.in_dec;
`else
  logic in_dec_unused;
  assign in_dec_unused = bus.in_dec;
  assign dec_in        = 1'b0;
`endif

  assign init_key = dec_in ? k_sch_i[nr_in] : k_sch_i[0];
  // decrypt walks the schedule from the top down
  assign rk_idx   = dec_q ? (nr_q - rnd_q) : rnd_q;
  assign last     = (rnd_q == nr_q);

  aes_round u_round (
    .state_i      (blk_q),
    .key_i        (k_sch_i[rk_idx]),
    .dec_i        (dec_q),
    .final_i      (last),
    .next_state_o (rnd_out)
  );

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    nr_d      = nr_q;
    dec_d     = dec_q;
    blk_d     = blk_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        load     = bus.in_valid;
      end
      S_RUN: begin
        blk_d = rnd_out;
        if (last) state_d = S_DONE;
        else      rnd_d   = rnd_q + 4'd1;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          state_d = S_IDLE;
          load    = bus.in_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_RUN;
      rnd_d   = 4'd1;
      nr_d    = nr_in;
      dec_d   = dec_in;
      blk_d   = AddRoundKey(bus.in_data, init_key);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      nr_q    <= 4'd10;
      dec_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      nr_q    <= nr_d;
      dec_q   <= dec_d;
      blk_q   <= blk_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = blk_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule
